// File: rtl/multi_timer_capture_pkg.sv
// Shared definitions for the multi-channel timer/capture block:
// channel FSM encoding and the per-channel mode constants.
package multi_timer_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_RESULT = 2'd2
    } chan_state_t;

    localparam logic MODE_ONE_SHOT   = 1'b0;
    localparam logic MODE_CONTINUOUS = 1'b1;

endpackage

// File: rtl/multi_timer_capture_timer_channel.sv
// One timer/capture channel: counts shared prescaler ticks between a start
// request and a stop request, then publishes the count for one cycle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | counter held at 0, waiting for enable_signal
// ST_COUNT  | counting ticks (saturating), waiting for final_signal
// ST_RESULT | result_valid pulse, counter cleared; back to IDLE or COUNT
module timer_channel
    import multi_timer_capture_pkg::*;
#(
    parameter int TIMER_COUNTER_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick,
    input  logic                           enable_signal,
    input  logic                           final_signal,
    input  logic                           mode,
    output logic [TIMER_COUNTER_WIDTH-1:0] counter_result,
    output logic                           result_valid,
    output logic                           overflow,
    output logic                           busy
);

    localparam int W = TIMER_COUNTER_WIDTH;
    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    chan_state_t  state;
    logic [W-1:0] count;
    logic [W-1:0] start_val;

    // The edge that enters COUNT already counts the tick of that cycle, so a
    // measurement spanning N cycles sees exactly N/(prescaler+1) ticks
    // regardless of prescaler phase.
    assign start_val = tick ? CNT_ONE : '0;

    // Channel FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            count          <= '0;
            counter_result <= '0;
            result_valid   <= 1'b0;
            overflow       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    count <= '0;
                    busy  <= 1'b0;
                    // final_signal is deliberately ignored here, even when
                    // it arrives together with enable_signal.
                    if (enable_signal) begin
                        state    <= ST_COUNT;
                        count    <= start_val;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (final_signal) begin
                        // Capture the pre-increment value; a coincident tick
                        // is dropped.
                        state          <= ST_RESULT;
                        counter_result <= count;
                        result_valid   <= 1'b1;
                        count          <= '0;
                        busy           <= 1'b0;
                    end else if (tick) begin
                        if (count == CNT_MAX) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + CNT_ONE;
                        end
                    end
                end
                ST_RESULT: begin
                    if (mode == MODE_CONTINUOUS) begin
                        state    <= ST_COUNT;
                        count    <= start_val;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        count <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_timer_capture.sv
// Multi-channel timer/capture: one shared prescaler tick generator feeding
// CHANNELS independent timer_channel instances.
module multi_timer_capture
    import multi_timer_capture_pkg::*;
#(
    parameter int CHANNELS            = 4,
    parameter int TIMER_COUNTER_WIDTH = 16,
    parameter int PRESCALER_WIDTH     = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [PRESCALER_WIDTH-1:0]              prescaler,
    input  logic [CHANNELS-1:0]                     enable_signal,
    input  logic [CHANNELS-1:0]                     final_signal,
    input  logic [CHANNELS-1:0]                     mode,
    output logic [CHANNELS*TIMER_COUNTER_WIDTH-1:0] counter_result,
    output logic [CHANNELS-1:0]                     result_valid,
    output logic [CHANNELS-1:0]                     overflow,
    output logic [CHANNELS-1:0]                     busy
);

    localparam int W = TIMER_COUNTER_WIDTH;

    logic [PRESCALER_WIDTH-1:0] pre_cnt;
    logic                       tick;

    // Using >= rather than == lets a lowered prescaler pull an overshot
    // count back to 0 on the next cycle, with a tick.
    assign tick = (pre_cnt >= prescaler);

    // Shared prescaler: counts 0..prescaler, wraps on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRESCALER_WIDTH'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        timer_channel #(
            .TIMER_COUNTER_WIDTH(W)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .tick          (tick),
            .enable_signal (enable_signal[i]),
            .final_signal  (final_signal[i]),
            .mode          (mode[i]),
            .counter_result(counter_result[i*W +: W]),
            .result_valid  (result_valid[i]),
            .overflow      (overflow[i]),
            .busy          (busy[i])
        );
    end

endmodule

// File: tb/tb_multi_timer_capture.sv
// Directed bench: two instances (16-bit and 4-bit counters) share stimulus;
// expected values are hand-computed from the cycle timing.
module tb_multi_timer_capture;

    logic        clk;
    logic        rst;
    logic [15:0] prescaler;
    logic [3:0]  en;
    logic [3:0]  fin;
    logic [3:0]  mode;

    logic [63:0] res16;
    logic [3:0]  vld16, ovf16, busy16;
    logic [15:0] res4;
    logic [3:0]  vld4, ovf4, busy4;

    int total = 0;
    int bad   = 0;

    multi_timer_capture #(
        .CHANNELS(4), .TIMER_COUNTER_WIDTH(16), .PRESCALER_WIDTH(16)
    ) dut16 (
        .clk(clk), .rst(rst), .prescaler(prescaler),
        .enable_signal(en), .final_signal(fin), .mode(mode),
        .counter_result(res16), .result_valid(vld16),
        .overflow(ovf16), .busy(busy16)
    );

    multi_timer_capture #(
        .CHANNELS(4), .TIMER_COUNTER_WIDTH(4), .PRESCALER_WIDTH(16)
    ) dut4 (
        .clk(clk), .rst(rst), .prescaler(prescaler),
        .enable_signal(en), .final_signal(fin), .mode(mode),
        .counter_result(res4), .result_valid(vld4),
        .overflow(ovf4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; afterwards outputs of that edge are stable and new
    // inputs may be driven for the next edge.
    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        prescaler = 16'd0;
        en        = 4'b0;
        fin       = 4'b0;
        mode      = 4'b0;
        tick_clk();
        tick_clk();

        chk("rst_res16",  res16,  64'd0);
        chk("rst_vld16",  vld16,  64'd0);
        chk("rst_ovf16",  ovf16,  64'd0);
        chk("rst_busy16", busy16, 64'd0);
        chk("rst_res4",   res4,   64'd0);
        chk("rst_busy4",  busy4,  64'd0);
        rst = 1'b0;
        tick_clk();

        // ch0, prescaler 0: enable, final 10 edges later -> 10
        en[0] = 1'b1;
        tick_clk();
        en[0] = 1'b0;
        chk("c0_busy_start", busy16[0], 64'd1);
        chk("c0_vld_quiet", vld16[0], 64'd0);
        repeat (9) tick_clk();
        fin[0] = 1'b1;
        tick_clk();
        fin[0] = 1'b0;
        chk("c0_vld",   vld16[0],       64'd1);
        chk("c0_res16", res16[15:0],    64'd10);
        chk("c0_res4",  res4[3:0],      64'd10);
        chk("c0_busy_result", busy16[0], 64'd0);
        tick_clk();
        chk("c0_vld_one_cycle", vld16[0], 64'd0);
        chk("c0_hold",  res16[15:0],    64'd10);
        chk("c0_idle_busy", busy16[0],  64'd0);

        // ch1, prescaler 3: 40 cycles -> 10 ticks
        prescaler = 16'd3;
        en[1] = 1'b1;
        tick_clk();
        en[1] = 1'b0;
        repeat (39) tick_clk();
        fin[1] = 1'b1;
        tick_clk();
        fin[1] = 1'b0;
        chk("c1_vld",   vld16[1],       64'd1);
        chk("c1_res16", res16[31:16],   64'd10);
        chk("c1_c0_untouched", res16[15:0], 64'd10);
        chk("c1_c0_no_vld", vld16[0],   64'd0);
        tick_clk();

        // ch2, prescaler 0: 20 cycles; 4-bit saturates at 15 with overflow
        prescaler = 16'd0;
        en[2] = 1'b1;
        tick_clk();
        en[2] = 1'b0;
        repeat (19) tick_clk();
        fin[2] = 1'b1;
        tick_clk();
        fin[2] = 1'b0;
        chk("c2_res16", res16[47:32], 64'd20);
        chk("c2_ovf16", ovf16[2],     64'd0);
        chk("c2_res4",  res4[11:8],   64'd15);
        chk("c2_ovf4",  ovf4[2],      64'd1);
        chk("c2_vld4",  vld4[2],      64'd1);
        repeat (3) tick_clk();
        chk("c2_ovf4_sticky", ovf4[2], 64'd1);
        en[2] = 1'b1;
        tick_clk();
        en[2] = 1'b0;
        chk("c2_ovf4_cleared", ovf4[2], 64'd0);
        fin[2] = 1'b1;
        tick_clk();
        fin[2] = 1'b0;
        chk("c2_short_res4", res4[11:8], 64'd1);
        tick_clk();

        // ch3 continuous: final every 8 edges -> 8 first, then 7 each
        mode[3] = 1'b1;
        en[3] = 1'b1;
        tick_clk();
        en[3] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat ((k == 0) ? 7 : 6) tick_clk();
            fin[3] = 1'b1;
            tick_clk();
            fin[3] = 1'b0;
            chk($sformatf("c3_vld_%0d", k),  vld16[3],      64'd1);
            chk($sformatf("c3_res_%0d", k),  res16[63:48],  (k == 0) ? 64'd8 : 64'd7);
            chk($sformatf("c3_busy_lo_%0d", k), busy16[3],  64'd0);
            tick_clk();
            chk($sformatf("c3_busy_hi_%0d", k), busy16[3],  64'd1);
            chk($sformatf("c3_vld_lo_%0d", k),  vld16[3],   64'd0);
        end
        mode[3] = 1'b0;
        fin[3] = 1'b1;
        tick_clk();
        fin[3] = 1'b0;
        tick_clk();
        chk("c3_idle", busy16[3], 64'd0);

        // reset mid-count on ch0, with a coinciding final request
        en[0] = 1'b1;
        tick_clk();
        en[0] = 1'b0;
        repeat (4) tick_clk();
        rst    = 1'b1;
        fin[0] = 1'b1;
        tick_clk();
        rst    = 1'b0;
        fin[0] = 1'b0;
        chk("rst_mid_vld",  vld16,  64'd0);
        chk("rst_mid_busy", busy16, 64'd0);
        chk("rst_mid_res",  res16,  64'd0);
        chk("rst_mid_ovf4", ovf4,   64'd0);
        tick_clk();
        chk("rst_mid_vld_after", vld16, 64'd0);

        // enable and final together in IDLE: start only
        en[1]  = 1'b1;
        fin[1] = 1'b1;
        tick_clk();
        en[1]  = 1'b0;
        fin[1] = 1'b0;
        chk("ef_busy", busy16[1], 64'd1);
        chk("ef_vld",  vld16[1],  64'd0);
        tick_clk();
        chk("ef_still_busy", busy16[1], 64'd1);
        chk("ef_no_capture", res16[31:16], 64'd0);
        fin[1] = 1'b1;
        tick_clk();
        fin[1] = 1'b0;
        chk("ef_close_vld", vld16[1], 64'd1);
        chk("ef_close_res", res16[31:16], 64'd2);
        tick_clk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_timer_capture.md
MULTI_TIMER_CAPTURE -- requirements
Module: multi_timer_capture

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, meaning the number of independent timer channels.
REQ-002 The block SHALL have parameter TIMER_COUNTER_WIDTH, default 16, meaning the per-channel counter and result width.
REQ-003 The block SHALL have parameter PRESCALER_WIDTH, default 16, meaning the width of the shared prescaler reload.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 prescaler  input  PRESCALER_WIDTH  tick period minus one; 0 = tick every cycle.
REQ-008 enable_signal  input  CHANNELS  per-channel start request, level-sampled.
REQ-009 final_signal  input  CHANNELS  per-channel stop/capture request, level-sampled.
REQ-010 mode  input  CHANNELS  per-channel mode; 0 = one-shot, 1 = continuous re-arm.
REQ-011 counter_result  output  CHANNELS*TIMER_COUNTER_WIDTH  captured count; channel i at bits [i*W +: W].
REQ-012 result_valid  output  CHANNELS  one-cycle pulse, high the cycle counter_result[i] updates.
REQ-013 overflow  output  CHANNELS  sticky; high if channel saturated during its current or last measurement.
REQ-014 busy  output  CHANNELS  high while channel is in COUNT.

Function
REQ-015 Shared prescaler SHALL count 0..prescaler and assert an internal tick for one cycle when the count equals prescaler, then wrap to 0.
REQ-016 A change of prescaler mid-count SHALL take effect on the next compare; if count > new prescaler, the count SHALL wrap to 0 on the next cycle, with a tick.
REQ-017 Each channel SHALL implement the FSM IDLE, COUNT, RESULT.
REQ-018 IDLE: counter held at 0; enable_signal[i]=1 -> COUNT and overflow[i] cleared; otherwise stay.
REQ-019 COUNT: counter SHALL increment by 1 on each tick; final_signal[i]=1 -> RESULT.
REQ-020 Counter SHALL saturate at 2^W-1; a tick at saturation SHALL set overflow[i] and not wrap.
REQ-021 On the edge leaving COUNT, counter_result[i] SHALL load the counter value present in that cycle (pre-increment if tick coincides).
REQ-022 RESULT: result_valid[i]=1 for exactly this cycle; counter cleared to 0.
REQ-023 RESULT with mode[i]=0 SHALL go to IDLE; with mode[i]=1 SHALL go to COUNT directly (overflow cleared, counting from 0).
REQ-024 Capture latency: final_signal sampled at edge N gives counter_result and result_valid valid in cycle N+1.
REQ-025 enable_signal and final_signal both high in IDLE: SHALL go to COUNT only; final ignored that cycle.
REQ-026 enable_signal while in COUNT or RESULT SHALL be ignored.
REQ-027 counter_result[i] SHALL hold its value until the next capture on that channel.
REQ-028 Channels SHALL be fully independent; only the prescaler tick is shared.

Reset
REQ-029 rst SHALL force all channels to IDLE, counters, prescaler count, counter_result, result_valid, overflow and busy to 0 on the next edge.
REQ-030 rst asserted mid-measurement SHALL discard the measurement with no result_valid pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE=0, COUNT=1, RESULT=2, 2-bit) and mode constants.
REQ-032 One sub-module timer_channel SHALL implement a single channel; top SHALL hold the prescaler and a generate loop of CHANNELS instances.

Verification
REQ-033 prescaler=0, ch0 enable at cycle 10, final at cycle 20 -> result_valid[0] pulse cycle 21, counter_result[0]=10.
REQ-034 prescaler=3, ch1 enable, final 40 cycles later -> counter_result[1]=10, ticks every 4th cycle.
REQ-035 W=4, prescaler=0, ch2 final after 20 cycles -> counter_result[2]=15, overflow[2]=1 until next start.
REQ-036 mode[3]=1, final pulsed every 8 cycles -> consecutive result_valid[3] pulses, each counter_result[3]=7 after first, busy low only during RESULT.
REQ-037 rst asserted mid-COUNT on ch0 -> no result_valid, all outputs 0 next cycle; enable+final together in IDLE -> COUNT, no capture.
